chop_demod: RTL

- Synchronous chopper demodulator directly downstream of the chopper generator.
- Consumes the delayed chop phase and data-hold strobe together with the ADC sample stream.
- Per chop period, accumulates samples with sign set by phase: + in default phase, − in inverted phase. Samples inside hold windows are discarded.
- Emits one demodulated sum per full chop period, with per-phase sample counts, to the interlock comparison logic.

---
 rtl/chop_pkg.sv | 24 ++
 rtl/chop_demod_if.sv | 40 ++++
 rtl/chop_demod_sat_acc.sv | 77 +++++++
 rtl/chop_demod.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/chop_pkg.sv
// Shared types and constants for the chopper demodulator: FSM encoding,
// default widths and saturation-limit helpers.
package chop_pkg;

    localparam int ADC_WIDTH_DEF = 18;
    localparam int ACC_WIDTH_DEF = 40;
    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    // Symmetric saturation limits +/-(2^(width-1)-1), returned sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -sat_max(width);
    endfunction

endpackage

// File: rtl/chop_demod_if.sv
// Stimulus/result bundle between the chopper generator, ADC and the demodulator.
// offset_o exists only when CHOP_DEMOD_OFFSET_EN is defined.
interface chop_demod_if #(
    parameter int ADC_WIDTH = 18,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 16
) ();
    logic                        demod_en;
    logic                        chop_default;
    logic                        chop_i;
    logic                        hold_i;
    logic signed [ADC_WIDTH-1:0] adc_data;
    logic                        adc_valid;
    logic signed [ACC_WIDTH-1:0] result_o;
    logic        [CNT_WIDTH-1:0] n_pos_o;
    logic        [CNT_WIDTH-1:0] n_neg_o;
    logic                        result_valid_o;
    logic                        ovf_o;
`ifdef CHOP_DEMOD_OFFSET_EN
    logic signed [ACC_WIDTH-1:0] offset_o;

    modport master (
        output demod_en, chop_default, chop_i, hold_i, adc_data, adc_valid,
        input  result_o, n_pos_o, n_neg_o, result_valid_o, ovf_o, offset_o
    );
    modport slave (
        input  demod_en, chop_default, chop_i, hold_i, adc_data, adc_valid,
        output result_o, n_pos_o, n_neg_o, result_valid_o, ovf_o, offset_o
    );
`else
    modport master (
        output demod_en, chop_default, chop_i, hold_i, adc_data, adc_valid,
        input  result_o, n_pos_o, n_neg_o, result_valid_o, ovf_o
    );
    modport slave (
        input  demod_en, chop_default, chop_i, hold_i, adc_data, adc_valid,
        output result_o, n_pos_o, n_neg_o, result_valid_o, ovf_o
    );
`endif
endinterface

// File: rtl/chop_demod_sat_acc.sv
// Signed saturating accumulator: clear, restart (load) or accumulate +/-din,
// with a sticky overflow flag that restarts together with the sum.
module sat_acc
    import chop_pkg::*;
#(
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        load_i,
    input  logic                        add_i,
    input  logic                        sub_i,
    input  logic signed [IN_WIDTH-1:0]  din_i,
    output logic signed [ACC_WIDTH-1:0] acc_o,
    output logic                        ovf_o
);
    localparam logic signed [63:0]        MAX64   = sat_max(ACC_WIDTH);
    localparam logic signed [63:0]        MIN64   = sat_min(ACC_WIDTH);
    localparam logic signed [ACC_WIDTH:0] LIM_HI  = MAX64[ACC_WIDTH:0];
    localparam logic signed [ACC_WIDTH:0] LIM_LO  = MIN64[ACC_WIDTH:0];
    localparam logic signed [ACC_WIDTH-1:0] ACC_HI = LIM_HI[ACC_WIDTH-1:0];
    localparam logic signed [ACC_WIDTH-1:0] ACC_LO = LIM_LO[ACC_WIDTH-1:0];

    logic signed [ACC_WIDTH:0]   din_ext_s, oper_s, base_s, sum_s;
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                        ovf_d, ovf_q, ovf_base_s;

    // One guard bit above the accumulator makes the clamp test exact.
    always_comb begin
        din_ext_s  = (ACC_WIDTH+1)'(din_i);
        oper_s     = '0;
        if (add_i) begin
            oper_s = din_ext_s;
        end else if (sub_i) begin
            oper_s = -din_ext_s;
        end else begin
            oper_s = '0;
        end
        base_s     = load_i ? '0 : (ACC_WIDTH+1)'(acc_q);
        ovf_base_s = load_i ? 1'b0 : ovf_q;
        sum_s      = base_s + oper_s;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (!(load_i || add_i || sub_i)) begin
            acc_d = acc_q;
            ovf_d = ovf_q;
        end else if (sum_s > LIM_HI) begin
            acc_d = ACC_HI;
            ovf_d = 1'b1;
        end else if (sum_s < LIM_LO) begin
            acc_d = ACC_LO;
            ovf_d = 1'b1;
        end else begin
            acc_d = sum_s[ACC_WIDTH-1:0];
            ovf_d = ovf_base_s;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/chop_demod.sv
// Synchronous chopper demodulator: signed per-period sum of ADC samples with
// per-phase counts. CHOP_DEMOD_OFFSET_EN adds a phase-independent sum on offset_o.
module chop_demod
    import chop_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    chop_demod_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                      state_q, state_d;
    logic                        chop_prev_q;
    logic        [CNT_WIDTH-1:0] n_pos_q, n_pos_d, n_neg_q, n_neg_d;
    logic signed [ACC_WIDTH-1:0] result_q, result_d;
    logic        [CNT_WIDTH-1:0] n_pos_out_q, n_pos_out_d, n_neg_out_q, n_neg_out_d;
    logic                        valid_q, valid_d, ovf_out_q, ovf_out_d;
    logic                        pos_s, edge_s, accept_s, ovf_any_s;
    logic                        acc_clr_s, acc_load_s, acc_add_s, acc_sub_s;
    logic signed [ACC_WIDTH-1:0] acc_s;
    logic                        acc_ovf_s;

    sat_acc #(.IN_WIDTH(ADC_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc (
        .clk(clk), .rst(rst), .clr_i(acc_clr_s), .load_i(acc_load_s),
        .add_i(acc_add_s), .sub_i(acc_sub_s), .din_i(bus.adc_data),
        .acc_o(acc_s), .ovf_o(acc_ovf_s)
    );

`ifdef CHOP_DEMOD_OFFSET_EN
    logic signed [ACC_WIDTH-1:0] off_s, offset_q, offset_d;
    logic                        off_ovf_s;

    sat_acc #(.IN_WIDTH(ADC_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_off (
        .clk(clk), .rst(rst), .clr_i(acc_clr_s), .load_i(acc_load_s),
        .add_i(acc_add_s | acc_sub_s), .sub_i(1'b0), .din_i(bus.adc_data),
        .acc_o(off_s), .ovf_o(off_ovf_s)
    );
    assign ovf_any_s = acc_ovf_s | off_ovf_s;
`else
    assign ovf_any_s = acc_ovf_s;
`endif

    // Next-state logic: the sample on a period-start edge always opens the new period.
    always_comb begin
        pos_s       = (bus.chop_i == bus.chop_default);
        edge_s      = pos_s && (chop_prev_q != bus.chop_default);
        accept_s    = bus.adc_valid && !bus.hold_i;
        state_d     = state_q;
        n_pos_d     = n_pos_q;
        n_neg_d     = n_neg_q;
        result_d    = result_q;
        n_pos_out_d = n_pos_out_q;
        n_neg_out_d = n_neg_out_q;
        ovf_out_d   = ovf_out_q;
        valid_d     = 1'b0;
        acc_clr_s   = 1'b0;
        acc_load_s  = 1'b0;
        acc_add_s   = accept_s && pos_s;
        acc_sub_s   = accept_s && !pos_s;
        if (!bus.demod_en) begin
            state_d   = ST_IDLE;
            acc_clr_s = 1'b1;
            n_pos_d   = '0;
            n_neg_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_SYNC;
                    acc_clr_s = 1'b1;
                    n_pos_d   = '0;
                    n_neg_d   = '0;
                end
                ST_SYNC: begin
                    if (edge_s) begin
                        state_d    = ST_ACCUM;
                        acc_load_s = 1'b1;
                        n_pos_d    = (accept_s && pos_s)  ? CNT_ONE : '0;
                        n_neg_d    = (accept_s && !pos_s) ? CNT_ONE : '0;
                    end else begin
                        acc_add_s = 1'b0;
                        acc_sub_s = 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (edge_s) begin
                        result_d    = acc_s;
                        n_pos_out_d = n_pos_q;
                        n_neg_out_d = n_neg_q;
                        ovf_out_d   = ovf_any_s;
                        valid_d     = 1'b1;
                        acc_load_s  = 1'b1;
                        n_pos_d     = (accept_s && pos_s)  ? CNT_ONE : '0;
                        n_neg_d     = (accept_s && !pos_s) ? CNT_ONE : '0;
                    end else if (accept_s && pos_s) begin
                        n_pos_d = (n_pos_q == CNT_MAX) ? n_pos_q : n_pos_q + CNT_ONE;
                    end else if (accept_s) begin
                        n_neg_d = (n_neg_q == CNT_MAX) ? n_neg_q : n_neg_q + CNT_ONE;
                    end else begin
                        n_pos_d = n_pos_q;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    acc_clr_s = 1'b1;
                    n_pos_d   = '0;
                    n_neg_d   = '0;
                end
            endcase
        end
`ifdef CHOP_DEMOD_OFFSET_EN
        offset_d = (valid_d) ? off_s : offset_q;
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            chop_prev_q <= 1'b0;
            n_pos_q     <= '0;
            n_neg_q     <= '0;
            result_q    <= '0;
            n_pos_out_q <= '0;
            n_neg_out_q <= '0;
            valid_q     <= 1'b0;
            ovf_out_q   <= 1'b0;
`ifdef CHOP_DEMOD_OFFSET_EN
            offset_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            chop_prev_q <= bus.chop_i;
            n_pos_q     <= n_pos_d;
            n_neg_q     <= n_neg_d;
            result_q    <= result_d;
            n_pos_out_q <= n_pos_out_d;
            n_neg_out_q <= n_neg_out_d;
            valid_q     <= valid_d;
            ovf_out_q   <= ovf_out_d;
`ifdef CHOP_DEMOD_OFFSET_EN
            offset_q    <= offset_d;
`endif
        end
    end

    assign bus.result_o       = result_q;
    assign bus.n_pos_o        = n_pos_out_q;
    assign bus.n_neg_o        = n_neg_out_q;
    assign bus.result_valid_o = valid_q;
    assign bus.ovf_o          = ovf_out_q;
`ifdef CHOP_DEMOD_OFFSET_EN
    assign bus.offset_o       = offset_q;
`endif
endmodule
